// File: rtl/seat_pkg.sv
// Shared types for the seat occupancy table: entry state, command opcode,
// response status and controller state.
package seat_pkg;

    typedef enum logic [1:0] {
        S_EMPTY  = 2'd0,
        S_AWAY   = 2'd1,
        S_SEATED = 2'd2
    } seat_state_t;

    typedef enum logic [1:0] {
        OP_SEAT  = 2'd0,
        OP_AWAY  = 2'd1,
        OP_LEAVE = 2'd2,
        OP_QUERY = 2'd3
    } op_t;

    typedef enum logic [1:0] {
        ST_OK        = 2'd0,
        ST_OCCUPIED  = 2'd1,
        ST_NOT_OWNER = 2'd2,
        ST_BAD_SEAT  = 2'd3
    } status_t;

    typedef enum logic {
        RUN   = 1'b0,
        CLEAR = 1'b1
    } fsm_t;

endpackage

// File: rtl/seat_table_if.sv
// Command/response/expiry bus between the kiosk controller (master) and the
// seat table (slave).
interface seat_table_if #(
    parameter int NUM_SEATS = 32,
    parameter int ID_W      = 32,
    parameter int TIME_W    = 11,
    parameter int SEAT_W    = $clog2(NUM_SEATS),
    parameter int CNT_W     = $clog2(NUM_SEATS + 1)
);
    logic              clear_all;
    logic              cmd_valid;
    logic              cmd_ready;
    logic [1:0]        cmd_op;
    logic [SEAT_W-1:0] cmd_seat;
    logic [ID_W-1:0]   cmd_student;
    logic [TIME_W-1:0] now;
    logic [TIME_W-1:0] limit_time;
    logic              rsp_valid;
    logic [1:0]        rsp_status;
    logic [1:0]        rsp_state;
    logic [ID_W-1:0]   rsp_student;
    logic              expire_valid;
    logic [SEAT_W-1:0] expire_seat;
    logic [CNT_W-1:0]  occupied_cnt;

    modport master (
        output clear_all, cmd_valid, cmd_op, cmd_seat, cmd_student, now, limit_time,
        input  cmd_ready, rsp_valid, rsp_status, rsp_state, rsp_student,
               expire_valid, expire_seat, occupied_cnt
    );

    modport slave (
        input  clear_all, cmd_valid, cmd_op, cmd_seat, cmd_student, now, limit_time,
        output cmd_ready, rsp_valid, rsp_status, rsp_state, rsp_student,
               expire_valid, expire_seat, occupied_cnt
    );
endinterface

// File: rtl/seat_sweep.sv
// Background sweep: walks one entry per idle cycle and flags AWAY entries whose
// wrapped age exceeds limit_time.
module seat_sweep
    import seat_pkg::*;
#(
    parameter int NUM_SEATS = 32,
    parameter int TIME_W    = 11,
    parameter int IDX_W     = $clog2(NUM_SEATS)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              advance,
    input  seat_state_t       entry_state,
    input  logic [TIME_W-1:0] entry_stamp,
    input  logic [TIME_W-1:0] now,
    input  logic [TIME_W-1:0] limit_time,
    output logic [IDX_W-1:0]  ptr,
    output logic              expire
);
    localparam logic [IDX_W-1:0] LAST = IDX_W'(NUM_SEATS - 1);

    logic [TIME_W-1:0] age;

    // Subtraction at TIME_W bits gives the age modulo 2^TIME_W across wrap.
    assign age    = now - entry_stamp;
    assign expire = advance && (entry_state == S_AWAY) && (age > limit_time);

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            ptr <= '0;
        else if (advance)
            ptr <= (ptr == LAST) ? '0 : ptr + IDX_W'(1);
    end
endmodule

// File: rtl/seat_table.sv
// Seat occupancy table: owns per-seat storage, the RUN/CLEAR controller and
// command decode; the sweep sub-module releases stale AWAY seats.
module seat_table
    import seat_pkg::*;
#(
    parameter int NUM_SEATS = 32,
    parameter int ID_W      = 32,
    parameter int TIME_W    = 11,
    parameter int SEAT_W    = $clog2(NUM_SEATS),
    parameter int CNT_W     = $clog2(NUM_SEATS + 1)
) (
    input  logic       clk,
    input  logic       rst,
    seat_table_if.slave bus
);
    localparam int               IDX_W    = $clog2(NUM_SEATS);
    localparam logic [SEAT_W:0]  SEAT_LIM = (SEAT_W + 1)'(NUM_SEATS);
    localparam logic [IDX_W-1:0] LAST     = IDX_W'(NUM_SEATS - 1);

    seat_state_t       st_q    [NUM_SEATS];
    logic [ID_W-1:0]   own_q   [NUM_SEATS];
    logic [TIME_W-1:0] stamp_q [NUM_SEATS];

    fsm_t              state_q, state_d;
    logic [IDX_W-1:0]  clr_idx_q;
    logic              clr_wipe;

    logic              accept, seat_ok, cmd_wr, owner_match;
    logic [IDX_W-1:0]  idx;
    op_t               op;
    seat_state_t       cur_st, nxt_st;
    logic [ID_W-1:0]   cur_own, nxt_own;
    logic [TIME_W-1:0] nxt_stamp;
    status_t           status;
    logic              inc, dec;

    logic              sweep_adv, sweep_exp;
    logic [IDX_W-1:0]  sweep_ptr;

    assign bus.cmd_ready = !rst && (state_q == RUN) && !bus.clear_all;
    assign accept        = bus.cmd_valid && bus.cmd_ready;
    assign op            = op_t'(bus.cmd_op);
    assign seat_ok       = ({1'b0, bus.cmd_seat} < SEAT_LIM);
    assign idx           = bus.cmd_seat[IDX_W-1:0];

    // Out-of-range seats read as an empty entry so the response carries zeros.
    always_comb begin
        cur_st  = S_EMPTY;
        cur_own = '0;
        if (seat_ok) begin
            cur_st  = st_q[idx];
            cur_own = own_q[idx];
        end
    end

    assign owner_match = (cur_own == bus.cmd_student);

    always_comb begin
        nxt_st    = cur_st;
        nxt_own   = cur_own;
        nxt_stamp = '0;
        status    = ST_OK;
        cmd_wr    = 1'b0;
        if (!seat_ok) begin
            status = ST_BAD_SEAT;
        end else begin
            case (op)
                OP_SEAT: begin
                    if (cur_st == S_EMPTY || (cur_st == S_AWAY && owner_match)) begin
                        nxt_st    = S_SEATED;
                        nxt_own   = bus.cmd_student;
                        nxt_stamp = bus.now;
                        cmd_wr    = 1'b1;
                    end else begin
                        status = ST_OCCUPIED;
                    end
                end
                OP_AWAY: begin
                    if (cur_st == S_SEATED && owner_match) begin
                        nxt_st    = S_AWAY;
                        nxt_stamp = bus.now;
                        cmd_wr    = 1'b1;
                    end else begin
                        status = ST_NOT_OWNER;
                    end
                end
                OP_LEAVE: begin
                    if (cur_st != S_EMPTY && owner_match) begin
                        nxt_st  = S_EMPTY;
                        nxt_own = '0;
                        cmd_wr  = 1'b1;
                    end else begin
                        status = ST_NOT_OWNER;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= RUN;
            clr_idx_q <= '0;
        end else begin
            state_q   <= state_d;
            clr_idx_q <= (clr_wipe && clr_idx_q != LAST) ? clr_idx_q + IDX_W'(1) : '0;
        end
    end

    always_comb begin
        state_d  = state_q;
        clr_wipe = 1'b0;
        case (state_q)
            RUN:   if (bus.clear_all) state_d = CLEAR;
            CLEAR: begin
                clr_wipe = 1'b1;
                if (clr_idx_q == LAST) state_d = RUN;
            end
        endcase
    end

    // The sweep only runs when no command owns the table this cycle.
    assign sweep_adv = (state_q == RUN) && !accept;

    seat_sweep #(
        .NUM_SEATS (NUM_SEATS),
        .TIME_W    (TIME_W),
        .IDX_W     (IDX_W)
    ) u_sweep (
        .clk         (clk),
        .rst         (rst),
        .advance     (sweep_adv),
        .entry_state (st_q[sweep_ptr]),
        .entry_stamp (stamp_q[sweep_ptr]),
        .now         (bus.now),
        .limit_time  (bus.limit_time),
        .ptr         (sweep_ptr),
        .expire      (sweep_exp)
    );

    always_comb begin
        inc = 1'b0;
        dec = 1'b0;
        if (accept && cmd_wr) begin
            inc = (cur_st == S_EMPTY) && (nxt_st != S_EMPTY);
            dec = (cur_st != S_EMPTY) && (nxt_st == S_EMPTY);
        end else if (sweep_exp) begin
            dec = 1'b1;
        end else if (clr_wipe && st_q[clr_idx_q] != S_EMPTY) begin
            dec = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < NUM_SEATS; k++) begin
                st_q[k]    <= S_EMPTY;
                own_q[k]   <= '0;
                stamp_q[k] <= '0;
            end
        end else if (accept && cmd_wr) begin
            st_q[idx]    <= nxt_st;
            own_q[idx]   <= nxt_own;
            stamp_q[idx] <= nxt_stamp;
        end else if (sweep_exp) begin
            st_q[sweep_ptr]    <= S_EMPTY;
            own_q[sweep_ptr]   <= '0;
            stamp_q[sweep_ptr] <= '0;
        end else if (clr_wipe) begin
            st_q[clr_idx_q]    <= S_EMPTY;
            own_q[clr_idx_q]   <= '0;
            stamp_q[clr_idx_q] <= '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bus.rsp_valid    <= 1'b0;
            bus.rsp_status   <= '0;
            bus.rsp_state    <= '0;
            bus.rsp_student  <= '0;
            bus.expire_valid <= 1'b0;
            bus.expire_seat  <= '0;
            bus.occupied_cnt <= '0;
        end else begin
            bus.rsp_valid    <= accept;
            bus.expire_valid <= sweep_exp;
            if (accept) begin
                bus.rsp_status  <= status;
                bus.rsp_state   <= nxt_st;
                bus.rsp_student <= nxt_own;
            end
            if (sweep_exp)
                bus.expire_seat <= SEAT_W'(sweep_ptr);
            bus.occupied_cnt <= bus.occupied_cnt + CNT_W'(inc) - CNT_W'(dec);
        end
    end
endmodule

// File: tb/tb_seat_table.sv
// Bench for seat_table: directed vector table, randomized commands against a
// seat-level reference model, and hand sequences for expiry, clear and reset.
module tb_seat_table;
    localparam int NS = 32;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    seat_table_if #(.NUM_SEATS(NS), .SEAT_W(6)) bus ();

    seat_table #(.NUM_SEATS(NS), .SEAT_W(6)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        logic [1:0]  op;
        int          seat;
        logic [31:0] stu;
        logic [10:0] t;
        logic [1:0]  status;
        logic [1:0]  state;
        logic [31:0] own;
        int          cnt;
    } vec_t;

    vec_t vecs[16];
    int n_vec = 0;
    int n_bad = 0;

    // Reference model: seat state (0 EMPTY, 1 AWAY, 2 SEATED) and owner.
    int          m_st  [NS];
    logic [31:0] m_own [NS];

    int          r_op, r_seat, es, est, n, hits;
    logic [31:0] r_stu, eo;
    logic [10:0] r_t;
    bit          saw_rsp;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic send(input int op, input int seat, input logic [31:0] stu, input logic [10:0] t);
        bus.cmd_valid   = 1'b1;
        bus.cmd_op      = 2'(op);
        bus.cmd_seat    = 6'(seat);
        bus.cmd_student = stu;
        bus.now         = t;
        @(posedge clk); #1;
        bus.cmd_valid   = 1'b0;
    endtask

    function automatic void model_reset();
        for (int k = 0; k < NS; k++) begin
            m_st[k]  = 0;
            m_own[k] = '0;
        end
    endfunction

    function automatic int model_cnt();
        int c = 0;
        for (int k = 0; k < NS; k++) if (m_st[k] != 0) c++;
        return c;
    endfunction

    function automatic void model_cmd(input int op, input int seat, input logic [31:0] stu,
                                      output int status, output int state, output logic [31:0] own);
        status = 0;
        if (seat >= NS) begin
            status = 3; state = 0; own = '0;
            return;
        end
        case (op)
            0: if (m_st[seat] == 0 || (m_st[seat] == 1 && m_own[seat] == stu)) begin
                   m_st[seat] = 2; m_own[seat] = stu;
               end else status = 1;
            1: if (m_st[seat] == 2 && m_own[seat] == stu) m_st[seat] = 1;
               else status = 2;
            2: if (m_st[seat] != 0 && m_own[seat] == stu) begin
                   m_st[seat] = 0; m_own[seat] = '0;
               end else status = 2;
            default: ;
        endcase
        state = m_st[seat];
        own   = m_own[seat];
    endfunction

    task automatic check_rsp(input string tag, input int status, input int state,
                             input logic [31:0] own, input int cnt);
        check({tag, "_valid"},  bus.rsp_valid, 1);
        check({tag, "_status"}, bus.rsp_status, status);
        check({tag, "_state"},  bus.rsp_state, state);
        check({tag, "_owner"},  bus.rsp_student, own);
        check({tag, "_cnt"},    bus.occupied_cnt, cnt);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        // op, seat, student, now, status, state, owner, occupied_cnt
        vecs[0]  = '{2'd0,  3, 32'h1234, 11'd10, 2'd0, 2'd2, 32'h1234, 1};
        vecs[1]  = '{2'd0,  3, 32'h5678, 11'd11, 2'd1, 2'd2, 32'h1234, 1};
        vecs[2]  = '{2'd1,  5, 32'h1111, 11'd12, 2'd2, 2'd0, 32'h0,    1};
        vecs[3]  = '{2'd0,  5, 32'h1111, 11'd30, 2'd0, 2'd2, 32'h1111, 2};
        vecs[4]  = '{2'd1,  5, 32'h1111, 11'd31, 2'd0, 2'd1, 32'h1111, 2};
        vecs[5]  = '{2'd0,  5, 32'h1111, 11'd32, 2'd0, 2'd2, 32'h1111, 2};
        vecs[6]  = '{2'd0,  5, 32'h2222, 11'd33, 2'd1, 2'd2, 32'h1111, 2};
        vecs[7]  = '{2'd2,  5, 32'h2222, 11'd34, 2'd2, 2'd2, 32'h1111, 2};
        vecs[8]  = '{2'd2,  5, 32'h1111, 11'd35, 2'd0, 2'd0, 32'h0,    1};
        vecs[9]  = '{2'd0, 40, 32'h9999, 11'd36, 2'd3, 2'd0, 32'h0,    1};
        vecs[10] = '{2'd3,  3, 32'h0,    11'd37, 2'd0, 2'd2, 32'h1234, 1};
        vecs[11] = '{2'd0, 31, 32'hABCD, 11'd38, 2'd0, 2'd2, 32'hABCD, 2};
        vecs[12] = '{2'd0, 32, 32'hABCD, 11'd39, 2'd3, 2'd0, 32'h0,    2};
        vecs[13] = '{2'd2, 31, 32'hABCD, 11'd40, 2'd0, 2'd0, 32'h0,    1};
        vecs[14] = '{2'd1,  3, 32'h5678, 11'd41, 2'd2, 2'd2, 32'h1234, 1};
        vecs[15] = '{2'd2,  3, 32'h1234, 11'd42, 2'd0, 2'd0, 32'h0,    0};

        bus.clear_all = 1'b0; bus.cmd_valid = 1'b0; bus.cmd_op = '0; bus.cmd_seat = '0;
        bus.cmd_student = '0; bus.now = '0; bus.limit_time = 11'd2047;
        model_reset();

        repeat (3) @(posedge clk);
        #1;
        check("rst_ready", bus.cmd_ready, 0);
        check("rst_rsp_valid", bus.rsp_valid, 0);
        check("rst_expire_valid", bus.expire_valid, 0);
        check("rst_cnt", bus.occupied_cnt, 0);
        rst = 1'b0;
        #1;
        check("ready_after_rst", bus.cmd_ready, 1);

        for (int i = 0; i < 16; i++) begin
            send(vecs[i].op, vecs[i].seat, vecs[i].stu, vecs[i].t);
            check_rsp($sformatf("vec%0d", i), vecs[i].status, vecs[i].state, vecs[i].own, vecs[i].cnt);
            @(posedge clk); #1;
            check($sformatf("vec%0d_pulse", i), bus.rsp_valid, 0);
        end

        // Back-to-back random commands; limit is maximal so nothing can expire.
        for (int i = 0; i < 300; i++) begin
            if ($urandom_range(0, 7) == 0) begin
                @(posedge clk); #1;
                check("rand_idle_rsp", bus.rsp_valid, 0);
            end else begin
                r_op   = int'($urandom_range(0, 3));
                r_seat = ($urandom_range(0, 9) == 0) ? int'($urandom_range(32, 63))
                                                     : int'($urandom_range(8, 15));
                r_stu  = 32'($urandom_range(1, 3));
                r_t    = 11'($urandom_range(0, 2047));
                model_cmd(r_op, r_seat, r_stu, es, est, eo);
                send(r_op, r_seat, r_stu, r_t);
                check_rsp("rand", es, est, eo, model_cnt());
            end
            check("rand_no_expire", bus.expire_valid, 0);
        end

        // Fill seats 0..3, then clear with a colliding command.
        for (int k = 0; k < 4; k++) begin
            model_cmd(0, k, 32'h100 + 32'(k), es, est, eo);
            send(0, k, 32'h100 + 32'(k), 11'd5);
            check_rsp("fill", es, est, eo, model_cnt());
        end
        bus.clear_all = 1'b1; bus.cmd_valid = 1'b1; bus.cmd_op = 2'd0;
        bus.cmd_seat = 6'd10; bus.cmd_student = 32'h55;
        #1;
        check("ready_low_on_clear", bus.cmd_ready, 0);
        @(posedge clk); #1;
        bus.clear_all = 1'b0; bus.cmd_valid = 1'b0;
        n = 0; saw_rsp = 1'b0;
        while (!bus.cmd_ready && n < 40) begin
            if (bus.rsp_valid) saw_rsp = 1'b1;
            n++;
            @(posedge clk); #1;
        end
        check("clear_ready_low_cycles", n, 32);
        check("clear_cmd_not_accepted", saw_rsp, 0);
        check("clear_cnt", bus.occupied_cnt, 0);
        model_reset();
        for (int k = 0; k < 4; k++) begin
            send(3, k, 32'h0, 11'd5);
            check_rsp("clear_query", 0, 0, 32'h0, 0);
        end
        send(3, 10, 32'h0, 11'd5);
        check_rsp("clear_query10", 0, 0, 32'h0, 0);
        send(3, 12, 32'h0, 11'd5);
        check_rsp("clear_query12", 0, 0, 32'h0, 0);

        // Expiry: AWAY at 20 with limit 50 survives at 70, goes at 71.
        bus.limit_time = 11'd50;
        send(0, 3, 32'h1234, 11'd10);
        check_rsp("exp_seat", 0, 2, 32'h1234, 1);
        send(1, 3, 32'h1234, 11'd20);
        check_rsp("exp_away", 0, 1, 32'h1234, 1);
        bus.now = 11'd70; hits = 0;
        repeat (40) begin
            @(posedge clk); #1;
            if (bus.expire_valid) hits++;
        end
        check("no_expire_at_limit", hits, 0);
        bus.now = 11'd71; n = 0;
        while (!bus.expire_valid && n < 40) begin
            @(posedge clk); #1;
            n++;
        end
        check("expire_seen", bus.expire_valid, 1);
        check("expire_latency_ok", n <= 33, 1);
        check("expire_seat", bus.expire_seat, 3);
        check("expire_cnt", bus.occupied_cnt, 0);
        @(posedge clk); #1;
        check("expire_pulse", bus.expire_valid, 0);
        send(3, 3, 32'h0, 11'd71);
        check_rsp("expire_query", 0, 0, 32'h0, 0);

        // Wrapped age: AWAY at 2040, limit 20: age 20 at now=12, 21 at now=13.
        bus.limit_time = 11'd20;
        send(0, 7, 32'h77, 11'd2030);
        send(1, 7, 32'h77, 11'd2040);
        check_rsp("wrap_away", 0, 1, 32'h77, 1);
        bus.now = 11'd12; hits = 0;
        repeat (40) begin
            @(posedge clk); #1;
            if (bus.expire_valid) hits++;
        end
        check("wrap_no_expire", hits, 0);
        bus.now = 11'd13; n = 0;
        while (!bus.expire_valid && n < 40) begin
            @(posedge clk); #1;
            n++;
        end
        check("wrap_expire_seen", bus.expire_valid, 1);
        check("wrap_expire_seat", bus.expire_seat, 7);
        check("wrap_expire_cnt", bus.occupied_cnt, 0);

        // Reset in the middle of a clear, before the wipe reaches seat 20.
        bus.limit_time = 11'd2047;
        send(0, 20, 32'h2020, 11'd0);
        check_rsp("pre_rst_seat", 0, 2, 32'h2020, 1);
        bus.clear_all = 1'b1;
        @(posedge clk); #1;
        bus.clear_all = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        check("midclr_rst_ready", bus.cmd_ready, 0);
        check("midclr_rst_rsp_valid", bus.rsp_valid, 0);
        check("midclr_rst_status", bus.rsp_status, 0);
        check("midclr_rst_state", bus.rsp_state, 0);
        check("midclr_rst_student", bus.rsp_student, 0);
        check("midclr_rst_expire_valid", bus.expire_valid, 0);
        check("midclr_rst_expire_seat", bus.expire_seat, 0);
        check("midclr_rst_cnt", bus.occupied_cnt, 0);
        rst = 1'b0;
        @(posedge clk); #1;
        check("midclr_ready_after", bus.cmd_ready, 1);
        send(3, 20, 32'h0, 11'd0);
        check_rsp("midclr_query", 0, 0, 32'h0, 0);
        send(0, 20, 32'h2021, 11'd1);
        check_rsp("midclr_reseat", 0, 2, 32'h2021, 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule

// File: doc/seat_table.md
# seat_table

Clocked, parametrised seat-occupancy table for the school seating system. It holds owner student number, timestamp and state for NUM_SEATS seats and executes SEAT, AWAY, LEAVE and QUERY commands through a valid/ready handshake, returning one status per command. A background sweep releases AWAY seats whose absence exceeds limit_time. It sits between the kiosk/controller FSM and the display and occupancy logic.

## Interface
- NUM_SEATS, 32: number of seats, ≥2.
- ID_W, 32: student number width.
- TIME_W, 11: timestamp width, wrapping.
- SEAT_W, $clog2(NUM_SEATS): seat index width (derived).
- CNT_W, $clog2(NUM_SEATS+1): occupancy count width (derived).
- clk  in  1  single clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- clear_all  in  1  synchronous request to wipe the table.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  command accepted when cmd_valid && cmd_ready.
- cmd_op  in  2  0 SEAT, 1 AWAY, 2 LEAVE, 3 QUERY.
- cmd_seat  in  SEAT_W  target seat.
- cmd_student  in  ID_W  requesting student.
- now  in  TIME_W  current time.
- limit_time  in  TIME_W  maximum AWAY duration.
- rsp_valid  out  1  one-cycle response pulse.
- rsp_status  out  2  0 OK, 1 OCCUPIED, 2 NOT_OWNER, 3 BAD_SEAT.
- rsp_state  out  2  seat state after the command (0 EMPTY, 1 AWAY, 2 SEATED).
- rsp_student  out  ID_W  seat owner after the command.
- expire_valid  out  1  one-cycle pulse when the sweep releases a seat.
- expire_seat  out  SEAT_W  seat released.
- occupied_cnt  out  CNT_W  number of non-EMPTY seats.

## Operation
- Each entry holds state (EMPTY/AWAY/SEATED), owner, and stamp (time of the last SEAT or AWAY).
- FSM states are RUN and CLEAR. rst forces RUN with all entries EMPTY, owner 0, stamp 0, and every output 0.
- cmd_ready = (state==RUN) && !clear_all.
- clear_all in RUN → CLEAR. CLEAR wipes entry k in cycle k (k = 0..NUM_SEATS-1), then returns to RUN. occupied_cnt is 0 on return. clear_all asserted during CLEAR is ignored.
- Command execution when cmd_seat ≥ NUM_SEATS: BAD_SEAT, no change.
- SEAT:
  - EMPTY → SEATED; owner = student; stamp = now; OK.
  - AWAY with owner == student → SEATED; stamp = now; OK.
  - Any SEATED seat, or AWAY with a different owner → OCCUPIED; no change.
- AWAY: SEATED with matching owner → AWAY; stamp = now; OK. Otherwise NOT_OWNER; no change.
- LEAVE: non-EMPTY with matching owner → EMPTY; owner and stamp cleared; OK. Otherwise NOT_OWNER.
- QUERY: no change; OK.
- Sweep:
  - sweep_ptr examines one entry in every RUN cycle with no accepted command, then increments. It wraps from NUM_SEATS-1 to 0.
  - Cycles with an accepted command stall the pointer, so a command and the sweep never touch an entry in the same cycle.
  - Expiry condition: state==AWAY && ((now - stamp) mod 2^TIME_W) > limit_time (strict). On expiry the entry is set EMPTY, owner and stamp are cleared, and expire_valid/expire_seat are raised.
- occupied_cnt is updated incrementally: +1 on EMPTY→non-EMPTY, −1 on non-EMPTY→EMPTY.

## Timing
- Command accepted at edge N → table updated at edge N. rsp_* valid during cycle N+1 for exactly one cycle.
- Back-to-back commands sustain 1 per cycle. A command reads the table state left by the previous command.
- Expiry is detected in the sweep cycle and the entry is written at that edge. expire_valid is registered and high the following cycle.
- Worst-case release latency after the deadline passes is NUM_SEATS non-command RUN cycles.
- CLEAR lasts NUM_SEATS cycles. cmd_ready is low throughout, and low in the cycle clear_all is sampled.
- rst mid-CLEAR or mid-command: table zeroed immediately. No pending rsp_valid or expire_valid survives.
- occupied_cnt is registered and consistent with the table at every edge.

## Structure
- seat_pkg holds:
  - seat_state_t enum (EMPTY=0, AWAY=1, SEATED=2).
  - op_t enum (SEAT, AWAY, LEAVE, QUERY).
  - status_t enum (OK, OCCUPIED, NOT_OWNER, BAD_SEAT).
- One sub-module, seat_sweep, contains the sweep pointer, the wrap logic and the modular timeout comparator. It outputs the index and an expire decision. seat_table owns the storage, the FSM and command decode.

## Test plan
- Reset, then SEAT seat 3 student 0x1234 at now=10 → rsp OK, state SEATED, owner 0x1234, occupied_cnt 1. SEAT seat 3 by 0x5678 → OCCUPIED, owner unchanged.
- AWAY seat 3 by 0x1234 at now=20 with limit_time=50. Hold commands off and advance now to 71 → expire_valid with expire_seat 3 within 32 cycles, occupied_cnt 0. At now=70 no expiry occurs.
- Wrap-around: AWAY at now=2040, limit 20, now=12 → diff 20, no expiry. now=13 → expiry.
- AWAY seat 5 by owner, then SEAT seat 5 by the same owner → OK, SEATED. LEAVE by another student → NOT_OWNER. LEAVE by the owner → EMPTY.
- cmd_seat=40 with NUM_SEATS=32 (SEAT_W=6 build) → BAD_SEAT, no state change.
- Fill 4 seats, pulse clear_all together with cmd_valid → command not accepted, cmd_ready low for 32 cycles, all QUERYs return EMPTY, occupied_cnt 0. Assert rst mid-CLEAR → immediate all-zero outputs.
